// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: numbers WB commits, counts cycles and drains records to the trace writer through a FIFO.
// Optional `TRACE_BACKPRESSURE_EN drives stall_req when the FIFO is nearly full.
module commit_trace_buffer #(
    parameter int DATA_W = 16,
    parameter int REG_W = 3,
    parameter int DEPTH = 8,
    parameter int CNT_W = 32,
    localparam int REC_W = 4 + REG_W + 4*DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cm_valid,
    input  logic [DATA_W-1:0] cm_pc,
    input  logic              cm_regwr,
    input  logic [REG_W-1:0]  cm_wreg,
    input  logic [DATA_W-1:0] cm_wdata,
    input  logic              cm_memrd,
    input  logic              cm_memwr,
    input  logic [DATA_W-1:0] cm_maddr,
    input  logic [DATA_W-1:0] cm_mdata,
    input  logic              cm_halt,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [CNT_W-1:0]  rec_inum,
    output logic [REC_W-1:0]  rec_data,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  inst_cnt,
    output logic              overflow,
    output logic              stall_req,
    output logic              done
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = CNT_W + REC_W;
    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
    state_t state_q, state_d;
    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d, occ;
    logic [CNT_W-1:0] cycle_q, cycle_d, inst_q, inst_d;
    logic ovf_q, ovf_d, done_q, done_d;
    logic full, empty, push, pop, head_halt;
    assign occ = wr_q - rd_q;
    assign empty = wr_q == rd_q;
    assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign rec_valid = !empty && state_q != DONE;
    assign {rec_inum, rec_data} = mem_q[rd_q[AW-1:0]];
    assign head_halt = rec_data[REC_W-1];
    assign pop = rec_valid && rec_ready;
    // a pop in the same cycle frees the slot, so a full FIFO can still accept
    assign push = cm_valid && state_q == RUN && (!full || pop);
    assign cycle_cnt = cycle_q;
    assign inst_cnt = inst_q;
    assign overflow = ovf_q;
    assign done = done_q;
`ifdef TRACE_BACKPRESSURE_EN
    assign stall_req = state_q == RUN && occ >= (AW+1)'(DEPTH-1);
`else
    assign stall_req = 1'b0;
`endif
    always_comb begin
        mem_d = mem_q;
        if (push)
            mem_d[wr_q[AW-1:0]] = {inst_q, cm_halt, cm_memrd, cm_memwr, cm_regwr, cm_wreg,
                                   cm_pc, cm_wdata, cm_maddr, cm_mdata};
        wr_d = push ? wr_q + (AW+1)'(1) : wr_q;
        rd_d = pop ? rd_q + (AW+1)'(1) : rd_q;
        cycle_d = cycle_q + CNT_W'(1);
        inst_d = push ? inst_q + CNT_W'(1) : inst_q;
        ovf_d = ovf_q || (cm_valid && state_q == RUN && full && !pop);
        state_d = (state_q == RUN && push && cm_halt) ? DRAIN :
                  (state_q == DRAIN && pop && head_halt) ? DONE : state_q;
        done_d = state_d == DONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wr_q <= '0;
            rd_q <= '0;
            cycle_q <= '0;
            inst_q <= '0;
            ovf_q <= 1'b0;
            done_q <= 1'b0;
            state_q <= RUN;
        end else begin
            mem_q <= mem_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            cycle_q <= cycle_d;
            inst_q <= inst_d;
            ovf_q <= ovf_d;
            done_q <= done_d;
            state_q <= state_d;
        end
    end
endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: directed checks of commit_trace_buffer with default parameters.
module tb_commit_trace_buffer;
    logic clk = 0, rst_n = 0;
    logic cm_valid = 0, cm_regwr = 0, cm_memrd = 0, cm_memwr = 0, cm_halt = 0, rec_ready = 0;
    logic [15:0] cm_pc = 0, cm_wdata = 0, cm_maddr = 0, cm_mdata = 0;
    logic [2:0] cm_wreg = 0;
    logic rec_valid, overflow, stall_req, done;
    logic [31:0] rec_inum, cycle_cnt, inst_cnt;
    logic [70:0] rec_data;
    int checks = 0, failures = 0;
`ifdef TRACE_BACKPRESSURE_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    commit_trace_buffer dut (
        .clk(clk), .rst_n(rst_n), .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_regwr(cm_regwr),
        .cm_wreg(cm_wreg), .cm_wdata(cm_wdata), .cm_memrd(cm_memrd), .cm_memwr(cm_memwr),
        .cm_maddr(cm_maddr), .cm_mdata(cm_mdata), .cm_halt(cm_halt), .rec_valid(rec_valid),
        .rec_ready(rec_ready), .rec_inum(rec_inum), .rec_data(rec_data), .cycle_cnt(cycle_cnt),
        .inst_cnt(inst_cnt), .overflow(overflow), .stall_req(stall_req), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [70:0] exp_rec(input logic [15:0] pc, input logic halt);
        return {halt, 1'b0, pc[1], 1'b1, pc[2:0], pc, pc + 16'd1, pc + 16'd2, pc + 16'd3};
    endfunction

    task automatic set_cm(input logic v, input logic [15:0] pc, input logic halt);
        cm_valid = v; cm_pc = pc; cm_halt = halt; cm_regwr = 1'b1; cm_wreg = pc[2:0];
        cm_wdata = pc + 16'd1; cm_memrd = 1'b0; cm_memwr = pc[1];
        cm_maddr = pc + 16'd2; cm_mdata = pc + 16'd3;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nxt;
        logic held;
        logic [70:0] hd;
        logic [31:0] hi;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", rec_valid, 0);
        chk("rst_data", rec_data, 0);
        chk("rst_inum", rec_inum, 0);
        chk("rst_cycle", cycle_cnt, 0);
        chk("rst_inst", inst_cnt, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_done", done, 0);
        chk("rst_stall", stall_req, 0);
        rst_n = 1;
        // five commits streamed straight through
        rec_ready = 1;
        for (int i = 0; i < 5; i++) begin
            set_cm(1, 16'(2*i), 0);
            if (i == 0) chk("t1_latency", rec_valid, 0);
            step();
            chk("t1_valid", rec_valid, 1);
            chk("t1_inum", rec_inum, i);
            chk("t1_data", rec_data, exp_rec(16'(2*i), 0));
        end
        set_cm(0, 0, 0);
        step();
        chk("t1_empty", rec_valid, 0);
        chk("t1_inst", inst_cnt, 5);
        chk("t1_cycle", cycle_cnt, 6);
        // fill with no sink, then overflow
        rec_ready = 0;
        for (int i = 0; i < 8; i++) begin
            set_cm(1, 16'(32 + 2*i), 0);
            step();
            chk("t2_stall", stall_req, BP && (i + 1 >= 7));
        end
        chk("t2_valid", rec_valid, 1);
        chk("t2_head", rec_inum, 5);
        chk("t2_inst", inst_cnt, 13);
        chk("t2_ovf0", overflow, 0);
        set_cm(1, 16'h40, 0);
        step();
        chk("t2_ovf1", overflow, 1);
        chk("t2_inst9", inst_cnt, 13);
        // full with push and pop every cycle
        rec_ready = 1;
        for (int i = 0; i < 20; i++) begin
            set_cm(1, 16'(256 + 2*i), 0);
            step();
            chk("t3_head", rec_inum, 6 + i);
        end
        chk("t3_inst", inst_cnt, 33);
        set_cm(0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            chk("t3_dinum", rec_inum, 25 + k);
            chk("t3_ddata", rec_data, exp_rec(16'(256 + 2*(12 + k)), 0));
            step();
        end
        chk("t3_empty", rec_valid, 0);
        // toggling sink with continuous commits
        nxt = 33;
        for (int i = 0; i < 28; i++) begin
            if (i < 12) set_cm(1, 16'(512 + 2*i), 0);
            else set_cm(0, 0, 0);
            rec_ready = (i >= 12) || (i % 2 == 1);
            if (rec_valid && rec_ready) begin
                chk("t5_inum", rec_inum, nxt);
                chk("t5_data", rec_data, exp_rec(16'(512 + 2*(nxt - 33)), 0));
                nxt++;
            end
            held = rec_valid && !rec_ready;
            hd = rec_data;
            hi = rec_inum;
            step();
            if (held) begin
                chk("t5_hold_data", rec_data, hd);
                chk("t5_hold_inum", rec_inum, hi);
            end
        end
        chk("t5_count", nxt, 45);
        chk("t5_empty", rec_valid, 0);
        // asynchronous reset mid-stream
        set_cm(1, 16'h60, 0);
        rec_ready = 0;
        step();
        #2 rst_n = 0;
        #1;
        chk("t6_valid", rec_valid, 0);
        chk("t6_data", rec_data, 0);
        chk("t6_inum", rec_inum, 0);
        chk("t6_cycle", cycle_cnt, 0);
        chk("t6_inst", inst_cnt, 0);
        chk("t6_ovf", overflow, 0);
        set_cm(0, 0, 0);
        step();
        rst_n = 1;
        rec_ready = 1;
        set_cm(1, 16'h30, 0);
        step();
        chk("t6_first", rec_inum, 0);
        chk("t6_cyc1", cycle_cnt, 1);
        // halt then drain to done
        set_cm(1, 16'h10, 1);
        step();
        chk("t4_hinum", rec_inum, 1);
        chk("t4_hdata", rec_data, exp_rec(16'h10, 1));
        set_cm(1, 16'h12, 0);
        chk("t4_done0", done, 0);
        step();
        chk("t4_done1", done, 1);
        chk("t4_nvalid", rec_valid, 0);
        set_cm(1, 16'h14, 0);
        step();
        chk("t4_done_hold", done, 1);
        chk("t4_inst", inst_cnt, 2);
        chk("t4_ovf", overflow, 0);
        chk("t4_valid_off", rec_valid, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
